vending_machine_gen: RTL and testbench
======================================

VENDING_MACHINE_GEN -- requirements
Module: vending_machine_gen

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- NUM_ITEMS, 4, number of selectable items.
- SEL_W, 2, item index width, equal to clog2(NUM_ITEMS).
- CREDIT_W, 8, width of the credit register.
- PRICE, 15, price of every item, in credit units.
- COIN1, 5, value of coin code 1.
- COIN2, 10, value of coin code 2.
- COIN3, 25, value of coin code 3.
- MAX_CREDIT, 50, highest credit the machine accepts.
- STOCK_W, 4, width of each stock counter.
- STOCK_INIT, 8, stock loaded by reset and by refill.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all logic samples on its rising edge.
- rst, in, 1, synchronous active-high reset.
- coin, in, 2, coin inserted this cycle: 0 none, 1 COIN1, 2 COIN2, 3 COIN3.
- sel_valid, in, 1, selection request this cycle.
- sel, in, SEL_W, item index requested.
- cancel, in, 1, refund request.
- refill, in, 1, restock all items.
- vend, out, 1, one-cycle dispense pulse.
- vend_item, out, SEL_W, index of the item dispensed.
- change_valid, out, 1, a change coin is issued this cycle.
- change_coin, out, 2, code of the change coin issued.
- coin_reject, out, 1, one-cycle pulse: the coin sampled last cycle was returned.
- sel_err, out, 1, one-cycle pulse: the selection was refused.
- credit, out, CREDIT_W, current credit.
- busy, out, 1, high in VEND and CHANGE.
- sold_out, out, NUM_ITEMS, bit i high when the stock of item i is 0.

Function
REQ-003 The state machine SHALL have four states: IDLE, CREDIT, VEND and CHANGE.
REQ-004 All outputs SHALL be registered.
REQ-005 vend, change_valid, coin_reject and sel_err SHALL be single-cycle pulses.
REQ-006 In IDLE and CREDIT, a nonzero coin SHALL add its value to credit, and IDLE SHALL then move to CREDIT.
REQ-007 If credit plus the coin value would exceed MAX_CREDIT, the coin SHALL be rejected: coin_reject pulses the next cycle and credit is unchanged.
REQ-008 A sel_valid in CREDIT SHALL be evaluated against credit that includes any coin accepted in the same cycle.
REQ-009 A selection SHALL be accepted when credit >= PRICE and the stock of item sel > 0; on the next edge the block enters VEND.
REQ-010 In VEND, for exactly one cycle: vend=1, vend_item=sel as sampled, stock[sel] is decremented, and credit is reduced by PRICE.
REQ-011 VEND SHALL go to CHANGE when the remainder is nonzero, otherwise to IDLE.
REQ-012 A refused selection (credit below PRICE or item sold out) SHALL pulse sel_err the next cycle and leave state, credit and stock unchanged.
REQ-013 In CREDIT, cancel SHALL have priority over sel_valid and go to CHANGE with the full credit, including any coin accepted in the same cycle.
REQ-014 In CHANGE, each cycle SHALL issue one coin: the largest coin value <= remaining credit, with change_valid=1 and credit reduced by that value.
REQ-015 CHANGE SHALL go to IDLE in the cycle credit reaches 0.
REQ-016 In VEND and CHANGE, coins SHALL be rejected (coin_reject), sel_valid, cancel and refill SHALL be ignored, and busy=1.
REQ-017 refill SHALL be honoured only in IDLE and SHALL load every stock counter with STOCK_INIT.
REQ-018 sold_out SHALL be combinational from the registered stock counters.
REQ-019 PRICE, COIN2, COIN3 and MAX_CREDIT SHALL be multiples of COIN1, and MAX_CREDIT SHALL be < 2^CREDIT_W.
REQ-020 A parameter violation of REQ-019 SHALL cause an elaboration-time error.

Reset
REQ-021 rst=1 SHALL, synchronously and regardless of state, force:
- state to IDLE;
- credit to 0;
- vend, change_valid, coin_reject, sel_err and busy to 0;
- change_coin and vend_item to 0;
- every stock counter to STOCK_INIT.
REQ-022 Reset taking effect in mid-VEND or mid-CHANGE SHALL discard any remaining change without issuing further coins.

Structure
REQ-023 The coin codes and state encodings SHALL live in the shared vending package/header and be reused by the bench.
REQ-024 One sub-module, vm_change_sel, SHALL combinationally map the remaining credit to the greedy coin code and its value.
REQ-025 The stock counters SHALL be a NUM_ITEMS-entry array inside the top module.

Verification (default parameters)
REQ-026 The bench SHALL cover the following directed scenarios:
- coin=2, coin=2, sel_valid with sel=0 -> vend=1 with vend_item=0, then one change coin code 1, then IDLE with credit 0.
- coin=3, coin=3, sel_valid with sel=1 -> vend, then change codes 3 then 2 on consecutive cycles, busy high throughout.
- coin=3, coin=2, cancel -> no vend; change codes 3 then 2; credit goes 35, 10, 0.
- credit 50, then coin=1 -> coin_reject next cycle, credit stays 50; coin during CHANGE also gives coin_reject.
- STOCK_INIT=2: two purchases of item 3 succeed, the third gives sel_err with sold_out[3]=1; refill in IDLE clears sold_out[3].
- rst asserted in the first CHANGE cycle after a 35 remainder -> next cycle IDLE, credit 0, no further change_valid, stock reloaded.

Source files
------------

// File: rtl/vending_machine_gen_pkg.sv
// Shared vending machine encodings: coin codes and controller states.
// Imported by the RTL and by the testbench.
package vending_machine_gen_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'd0,
      COIN_C1   = 2'd1,
      COIN_C2   = 2'd2,
      COIN_C3   = 2'd3
   } coin_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_CHANGE = 2'd3
   } state_e;

endpackage

// File: rtl/vending_machine_gen_change_sel.sv
// Greedy change picker: largest coin whose value fits in the remaining amount.
// Assumes COIN3 > COIN2 > COIN1 > 0.
module vm_change_sel
   import vending_machine_gen_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int COIN1    = 5,
   parameter int COIN2    = 10,
   parameter int COIN3    = 25
) (
   input  logic [CREDIT_W-1:0] amount,
   output logic [1:0]          coin_code,
   output logic [CREDIT_W-1:0] coin_value
);

   localparam logic [CREDIT_W-1:0] V1 = CREDIT_W'(COIN1);
   localparam logic [CREDIT_W-1:0] V2 = CREDIT_W'(COIN2);
   localparam logic [CREDIT_W-1:0] V3 = CREDIT_W'(COIN3);

   always_comb begin
      coin_code  = COIN_NONE;
      coin_value = '0;
      if (amount >= V3) begin
         coin_code  = COIN_C3;
         coin_value = V3;
      end else if (amount >= V2) begin
         coin_code  = COIN_C2;
         coin_value = V2;
      end else if (amount >= V1) begin
         coin_code  = COIN_C1;
         coin_value = V1;
      end
   end

endmodule

// File: rtl/vending_machine_gen.sv
// Coin-operated vending controller: credit accumulation, stock-checked selection,
// one-cycle dispense and greedy coin-by-coin change. All outputs are registered.
module vending_machine_gen
   import vending_machine_gen_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int SEL_W      = 2,
   parameter int CREDIT_W   = 8,
   parameter int PRICE      = 15,
   parameter int COIN1      = 5,
   parameter int COIN2      = 10,
   parameter int COIN3      = 25,
   parameter int MAX_CREDIT = 50,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           coin,
   input  logic                 sel_valid,
   input  logic [SEL_W-1:0]     sel,
   input  logic                 cancel,
   input  logic                 refill,
   output logic                 vend,
   output logic [SEL_W-1:0]     vend_item,
   output logic                 change_valid,
   output logic [1:0]           change_coin,
   output logic                 coin_reject,
   output logic                 sel_err,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy,
   output logic [NUM_ITEMS-1:0] sold_out
);

   if ((COIN1 <= 0) || (PRICE % COIN1 != 0) || (COIN2 % COIN1 != 0) ||
       (COIN3 % COIN1 != 0) || (MAX_CREDIT % COIN1 != 0) ||
       (MAX_CREDIT >= (2 ** CREDIT_W)) || ((2 ** SEL_W) < NUM_ITEMS)) begin : g_bad_params
      $error("vending_machine_gen: illegal parameter combination");
   end

   localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_INIT);

   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic [SEL_W-1:0]      vend_item_q, vend_item_d;
   logic [1:0]            change_coin_q, change_coin_d;
   logic                  vend_q, vend_d, change_valid_q, change_valid_d;
   logic                  coin_reject_q, coin_reject_d, sel_err_q, sel_err_d;
   logic                  busy_q, busy_d;
   logic [STOCK_W-1:0]    stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0]    stock_d [NUM_ITEMS];

   logic [CREDIT_W:0]     coin_val, coin_sum, credit_eff;
   logic                  coin_ok, sel_in_stock, sel_ok;
   logic [CREDIT_W-1:0]   chg_src, chg_val, chg_left;
   logic [1:0]            chg_code;

   always_comb begin
      coin_val = '0;
      case (coin)
         COIN_C1: coin_val = (CREDIT_W+1)'(COIN1);
         COIN_C2: coin_val = (CREDIT_W+1)'(COIN2);
         COIN_C3: coin_val = (CREDIT_W+1)'(COIN3);
         default: coin_val = '0;
      endcase
   end

   // Credit as seen by a same-cycle selection or cancel: includes an accepted coin.
   assign coin_sum   = {1'b0, credit_q} + coin_val;
   assign coin_ok    = (coin != COIN_NONE) && (coin_sum <= MAX_X);
   assign credit_eff = coin_ok ? coin_sum : {1'b0, credit_q};

   // An out-of-range index finds no stock and is refused like a sold-out item.
   always_comb begin
      sel_in_stock = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (SEL_W'(i) == sel) sel_in_stock = (stock_q[i] != '0);
      end
   end
   assign sel_ok = sel_in_stock && (credit_eff >= {1'b0, PRICE_N});

   assign chg_src  = (state_q == S_CREDIT) ? credit_eff[CREDIT_W-1:0] : credit_q;
   assign chg_left = chg_src - chg_val;

   vm_change_sel #(
      .CREDIT_W (CREDIT_W),
      .COIN1    (COIN1),
      .COIN2    (COIN2),
      .COIN3    (COIN3)
   ) u_change_sel (
      .amount     (chg_src),
      .coin_code  (chg_code),
      .coin_value (chg_val)
   );

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      vend_item_d    = vend_item_q;
      change_coin_d  = '0;
      vend_d         = 1'b0;
      change_valid_d = 1'b0;
      coin_reject_d  = 1'b0;
      sel_err_d      = 1'b0;
      busy_d         = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = stock_q[i];

      case (state_q)
         S_IDLE, S_CREDIT: begin
            coin_reject_d = (coin != COIN_NONE) && !coin_ok;
            credit_d      = credit_eff[CREDIT_W-1:0];
            if (state_q == S_IDLE) begin
               if (coin_ok) state_d = S_CREDIT;
               if (sel_valid) sel_err_d = 1'b1;
               if (refill) begin
                  for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = STOCK_FULL;
               end
            end else if (cancel) begin
               state_d        = S_CHANGE;
               busy_d         = 1'b1;
               change_valid_d = 1'b1;
               change_coin_d  = chg_code;
               credit_d       = chg_left;
            end else if (sel_valid) begin
               if (sel_ok) begin
                  state_d     = S_VEND;
                  busy_d      = 1'b1;
                  vend_d      = 1'b1;
                  vend_item_d = sel;
                  credit_d    = credit_eff[CREDIT_W-1:0] - PRICE_N;
                  for (int i = 0; i < NUM_ITEMS; i++) begin
                     if (SEL_W'(i) == sel) stock_d[i] = stock_q[i] - 1'b1;
                  end
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         // VEND and CHANGE both drain the remainder one coin per cycle.
         S_VEND, S_CHANGE: begin
            coin_reject_d = (coin != COIN_NONE);
            if (credit_q != '0) begin
               state_d        = S_CHANGE;
               busy_d         = 1'b1;
               change_valid_d = 1'b1;
               change_coin_d  = chg_code;
               credit_d       = chg_left;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         vend_item_q    <= '0;
         change_coin_q  <= '0;
         vend_q         <= 1'b0;
         change_valid_q <= 1'b0;
         coin_reject_q  <= 1'b0;
         sel_err_q      <= 1'b0;
         busy_q         <= 1'b0;
         for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_FULL;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         vend_item_q    <= vend_item_d;
         change_coin_q  <= change_coin_d;
         vend_q         <= vend_d;
         change_valid_q <= change_valid_d;
         coin_reject_q  <= coin_reject_d;
         sel_err_q      <= sel_err_d;
         busy_q         <= busy_d;
         for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
      end
   end

   always_comb begin
      sold_out = '0;
      for (int i = 0; i < NUM_ITEMS; i++) sold_out[i] = (stock_q[i] == '0);
   end

   assign vend         = vend_q;
   assign vend_item    = vend_item_q;
   assign change_valid = change_valid_q;
   assign change_coin  = change_coin_q;
   assign coin_reject  = coin_reject_q;
   assign sel_err      = sel_err_q;
   assign credit       = credit_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Bench for vending_machine_gen: a default instance and a STOCK_INIT=2 instance,
// driven from a vector table, plus a randomized coins-then-cancel change sequence.
module tb_vending_machine_gen;
   import vending_machine_gen_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       a_rst, a_sel_valid, a_cancel, a_refill;
   logic [1:0] a_coin, a_sel;
   logic       a_vend, a_change_valid, a_coin_reject, a_sel_err, a_busy;
   logic [1:0] a_vend_item, a_change_coin;
   logic [7:0] a_credit;
   logic [3:0] a_sold_out;

   logic       b_rst, b_sel_valid, b_cancel, b_refill;
   logic [1:0] b_coin, b_sel;
   logic       b_vend, b_change_valid, b_coin_reject, b_sel_err, b_busy;
   logic [1:0] b_vend_item, b_change_coin;
   logic [7:0] b_credit;
   logic [3:0] b_sold_out;

   vending_machine_gen dut (
      .clk(clk), .rst(a_rst), .coin(a_coin), .sel_valid(a_sel_valid), .sel(a_sel),
      .cancel(a_cancel), .refill(a_refill), .vend(a_vend), .vend_item(a_vend_item),
      .change_valid(a_change_valid), .change_coin(a_change_coin),
      .coin_reject(a_coin_reject), .sel_err(a_sel_err), .credit(a_credit),
      .busy(a_busy), .sold_out(a_sold_out)
   );

   vending_machine_gen #(.STOCK_INIT(2)) dut_s (
      .clk(clk), .rst(b_rst), .coin(b_coin), .sel_valid(b_sel_valid), .sel(b_sel),
      .cancel(b_cancel), .refill(b_refill), .vend(b_vend), .vend_item(b_vend_item),
      .change_valid(b_change_valid), .change_coin(b_change_coin),
      .coin_reject(b_coin_reject), .sel_err(b_sel_err), .credit(b_credit),
      .busy(b_busy), .sold_out(b_sold_out)
   );

   typedef struct packed {
      logic       vend;
      logic [1:0] item;
      logic       chg_v;
      logic [1:0] chg_c;
      logic       rej;
      logic       serr;
      logic [7:0] credit;
      logic       busy;
      logic [3:0] sold;
   } out_t;

   typedef struct packed {
      logic       which;
      logic       rst;
      logic [1:0] coin;
      logic       sv;
      logic [1:0] sel;
      logic       cancel;
      logic       refill;
      out_t       exp;
   } vec_t;

   vec_t       vecs[$];
   out_t       exp_q[$];
   logic       which_q[$];
   logic [1:0] code_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         row      = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %0d, expected %0d", row, name, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic r, input logic [1:0] c, input logic sv,
                      input logic [1:0] s, input logic cn, input logic rf,
                      input logic vd, input logic [1:0] it, input logic cv,
                      input logic [1:0] cc, input logic rj, input logic se,
                      input logic [7:0] cr, input logic bz, input logic [3:0] so);
      vec_t v;
      v.which = w; v.rst = r; v.coin = c; v.sv = sv; v.sel = s; v.cancel = cn;
      v.refill = rf;
      v.exp = '{vend: vd, item: it, chg_v: cv, chg_c: cc, rej: rj, serr: se,
                credit: cr, busy: bz, sold: so};
      vecs.push_back(v);
   endtask

   function automatic out_t get_act(input logic w);
      out_t o;
      if (!w) o = '{vend: a_vend, item: a_vend_item, chg_v: a_change_valid,
                    chg_c: a_change_coin, rej: a_coin_reject, serr: a_sel_err,
                    credit: a_credit, busy: a_busy, sold: a_sold_out};
      else    o = '{vend: b_vend, item: b_vend_item, chg_v: b_change_valid,
                    chg_c: b_change_coin, rej: b_coin_reject, serr: b_sel_err,
                    credit: b_credit, busy: b_busy, sold: b_sold_out};
      return o;
   endfunction

   task automatic idle_inputs();
      a_rst = 0; a_coin = 0; a_sel_valid = 0; a_sel = 0; a_cancel = 0; a_refill = 0;
      b_rst = 0; b_coin = 0; b_sel_valid = 0; b_sel = 0; b_cancel = 0; b_refill = 0;
   endtask

   task automatic check_out();
      out_t e, a;
      logic w;
      e = exp_q.pop_front();
      w = which_q.pop_front();
      a = get_act(w);
      chk("vend", int'(a.vend), int'(e.vend));
      chk("change_valid", int'(a.chg_v), int'(e.chg_v));
      chk("coin_reject", int'(a.rej), int'(e.rej));
      chk("sel_err", int'(a.serr), int'(e.serr));
      chk("credit", int'(a.credit), int'(e.credit));
      chk("busy", int'(a.busy), int'(e.busy));
      chk("sold_out", int'(a.sold), int'(e.sold));
      if (e.vend) chk("vend_item", int'(a.item), int'(e.item));
      if (e.chg_v) chk("change_coin", int'(a.chg_c), int'(e.chg_c));
   endtask

   // Inputs change on the falling edge; outputs are checked on the next falling edge.
   task automatic apply(input vec_t v);
      idle_inputs();
      if (!v.which) begin
         a_rst = v.rst; a_coin = v.coin; a_sel_valid = v.sv; a_sel = v.sel;
         a_cancel = v.cancel; a_refill = v.refill;
      end else begin
         b_rst = v.rst; b_coin = v.coin; b_sel_valid = v.sv; b_sel = v.sel;
         b_cancel = v.cancel; b_refill = v.refill;
      end
      exp_q.push_back(v.exp);
      which_q.push_back(v.which);
      @(negedge clk);
      check_out();
   endtask

   function automatic int coin_value(input logic [1:0] c);
      case (c)
         COIN_C1: return 5;
         COIN_C2: return 10;
         COIN_C3: return 25;
         default: return 0;
      endcase
   endfunction

   task automatic push_greedy(input int amount);
      int amt;
      amt = amount;
      while (amt >= 5) begin
         if (amt >= 25)      begin code_q.push_back(COIN_C3); amt -= 25; end
         else if (amt >= 10) begin code_q.push_back(COIN_C2); amt -= 10; end
         else                begin code_q.push_back(COIN_C1); amt -= 5;  end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      @(negedge clk);

      // dut (STOCK_INIT=8):  w rst coin sv sel can ref | vend item cv cc rej serr credit busy sold
      add(0,1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      add(0,0,2,0,0,0,0, 0,0,0,0,0,0,10,0,0);
      add(0,0,2,0,0,0,0, 0,0,0,0,0,0,20,0,0);
      add(0,0,0,1,0,0,0, 1,0,0,0,0,0, 5,1,0);
      add(0,0,0,0,0,0,0, 0,0,1,1,0,0, 0,1,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      add(0,0,3,0,0,0,0, 0,0,0,0,0,0,25,0,0);
      add(0,0,3,0,0,0,0, 0,0,0,0,0,0,50,0,0);
      add(0,0,0,1,1,0,0, 1,1,0,0,0,0,35,1,0);
      add(0,0,0,0,0,0,0, 0,0,1,3,0,0,10,1,0);
      add(0,0,0,0,0,0,0, 0,0,1,2,0,0, 0,1,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      add(0,0,3,0,0,0,0, 0,0,0,0,0,0,25,0,0);
      add(0,0,2,0,0,0,0, 0,0,0,0,0,0,35,0,0);
      add(0,0,0,0,0,1,0, 0,0,1,3,0,0,10,1,0);
      add(0,0,0,0,0,0,0, 0,0,1,2,0,0, 0,1,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      add(0,0,3,0,0,0,0, 0,0,0,0,0,0,25,0,0);
      add(0,0,3,0,0,0,0, 0,0,0,0,0,0,50,0,0);
      add(0,0,1,0,0,0,0, 0,0,0,0,1,0,50,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0,50,0,0);
      add(0,0,0,0,0,1,0, 0,0,1,3,0,0,25,1,0);
      add(0,0,1,0,0,0,0, 0,0,1,3,1,0, 0,1,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      add(0,0,0,1,0,0,0, 0,0,0,0,0,1, 0,0,0);
      add(0,0,1,0,0,0,0, 0,0,0,0,0,0, 5,0,0);
      add(0,0,0,1,0,0,0, 0,0,0,0,0,1, 5,0,0);
      add(0,0,2,1,2,0,0, 1,2,0,0,0,0, 0,1,0);
      add(0,0,3,1,1,1,1, 0,0,0,0,1,0, 0,0,0);
      add(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0);
      // dut_s (STOCK_INIT=2): sell out item 3, refill, then reset during change.
      add(1,1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b0000);
      add(1,0,2,0,0,0,0, 0,0,0,0,0,0,10,0,4'b0000);
      add(1,0,1,0,0,0,0, 0,0,0,0,0,0,15,0,4'b0000);
      add(1,0,0,1,3,0,0, 1,3,0,0,0,0, 0,1,4'b0000);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b0000);
      add(1,0,2,0,0,0,0, 0,0,0,0,0,0,10,0,4'b0000);
      add(1,0,1,0,0,0,0, 0,0,0,0,0,0,15,0,4'b0000);
      add(1,0,0,1,3,0,0, 1,3,0,0,0,0, 0,1,4'b1000);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b1000);
      add(1,0,2,0,0,0,0, 0,0,0,0,0,0,10,0,4'b1000);
      add(1,0,1,0,0,0,0, 0,0,0,0,0,0,15,0,4'b1000);
      add(1,0,0,1,3,0,0, 0,0,0,0,0,1,15,0,4'b1000);
      add(1,0,0,0,0,1,0, 0,0,1,2,0,0, 5,1,4'b1000);
      add(1,0,0,0,0,0,0, 0,0,1,1,0,0, 0,1,4'b1000);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b1000);
      add(1,0,0,0,0,0,1, 0,0,0,0,0,0, 0,0,4'b0000);
      add(1,0,2,0,0,0,0, 0,0,0,0,0,0,10,0,4'b0000);
      add(1,0,1,0,0,0,0, 0,0,0,0,0,0,15,0,4'b0000);
      add(1,0,0,1,3,0,0, 1,3,0,0,0,0, 0,1,4'b0000);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b0000);
      add(1,0,3,0,0,0,0, 0,0,0,0,0,0,25,0,4'b0000);
      add(1,0,3,0,0,0,0, 0,0,0,0,0,0,50,0,4'b0000);
      add(1,0,0,1,3,0,0, 1,3,0,0,0,0,35,1,4'b1000);
      add(1,0,0,0,0,0,1, 0,0,1,3,0,0,10,1,4'b1000);
      add(1,1,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b0000);
      add(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,4'b0000);

      foreach (vecs[i]) begin
         row = i;
         apply(vecs[i]);
      end

      // Random coins then cancel on dut; change must be the greedy breakdown.
      for (int t = 0; t < 8; t++) begin
         int exp_credit;
         int n;
         int budget;
         logic [1:0] c;
         row = 1000 + t;
         exp_credit = 0;
         n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) begin
            logic acc;
            c = 2'($urandom_range(1, 3));
            acc = (exp_credit + coin_value(c)) <= 50;
            idle_inputs();
            a_coin = c;
            @(negedge clk);
            if (acc) exp_credit += coin_value(c);
            chk("rand_credit", int'(a_credit), exp_credit);
            chk("rand_reject", int'(a_coin_reject), int'(!acc));
         end
         idle_inputs();
         a_cancel = 1'b1;
         push_greedy(exp_credit);
         @(negedge clk);
         idle_inputs();
         budget = 0;
         while (code_q.size() != 0 && budget < 12) begin
            if (a_change_valid) begin
               chk("rand_change_coin", int'(a_change_coin), int'(code_q.pop_front()));
               chk("rand_busy", int'(a_busy), 1);
            end
            budget++;
            @(negedge clk);
         end
         chk("rand_change_pending", code_q.size(), 0);
         code_q.delete();
         chk("rand_extra_change", int'(a_change_valid), 0);
         chk("rand_end_credit", int'(a_credit), 0);
         chk("rand_end_busy", int'(a_busy), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
